// File: rtl/garage_door_pkg.sv
// Shared types and helpers for the garage door controller.
package garage_door_pkg;

    typedef enum logic [2:0] {
        ST_CLOSED   = 3'd0,
        ST_OPENING  = 3'd1,
        ST_OPEN     = 3'd2,
        ST_CLOSING  = 3'd3,
        ST_STOPPED  = 3'd4,
        ST_FAULT    = 3'd5
    } door_state_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } door_dir_e;

    // ceil(log2(max(a,b)+1)), never less than 1
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = 1;
        while ((32'd1 << w) < (m + 32'd1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/door_travel_timer.sv
// Per-state cycle counter with clear, enable, hold and saturation; flags terminal count.
module door_travel_timer #(
    parameter int unsigned CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             hold,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !hold && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == limit);

endmodule

// File: rtl/garage_door_ctrl_p.sv
// Garage door controller: edge-triggered Activate, pause/reverse, travel timeout,
// optional auto-close and obstruction reversal.
module garage_door_ctrl_p
    import garage_door_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC    = 1000,
    parameter int unsigned AUTO_CLOSE_CYC = 0,
    parameter int unsigned PAUSE_MODE     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Activate,
    input  logic       UP_Max,
    input  logic       DN_Max,
    input  logic       Obstruct,
    input  logic       Fault_Clr,
    output logic       UP_M,
    output logic       DN_M,
    output logic       Fault,
    output logic [2:0] State
);

    localparam int unsigned      CNT_W      = cnt_width(TIMEOUT_CYC, AUTO_CLOSE_CYC);
    localparam logic [CNT_W-1:0] TRAVEL_LIM = CNT_W'(TIMEOUT_CYC - 32'd1);
    localparam logic [CNT_W-1:0] IDLE_LIM   =
        CNT_W'((AUTO_CLOSE_CYC == 32'd0) ? 32'd0 : AUTO_CLOSE_CYC - 32'd1);
    localparam bit AUTO_EN = (AUTO_CLOSE_CYC != 32'd0);
    localparam bit PAUSE   = (PAUSE_MODE != 32'd0);

    door_state_e      state;
    door_state_e      state_nxt;
    door_dir_e        last_dir;
    logic             act_d;
    logic             act_pulse;
    logic             tc;
    logic             timer_clr;
    logic             timer_en;
    logic             timer_hold;
    logic [CNT_W-1:0] timer_lim;

    assign act_pulse = Activate & ~act_d;

    // Counter restarts on every state change; in OPEN it measures idle time.
    assign timer_clr  = (state_nxt != state);
    assign timer_en   = (state == ST_OPENING) || (state == ST_CLOSING) || (state == ST_OPEN);
    assign timer_hold = (state == ST_OPEN) && Obstruct;
    assign timer_lim  = (state == ST_OPEN) ? IDLE_LIM : TRAVEL_LIM;

    door_travel_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (timer_clr),
        .en    (timer_en),
        .hold  (timer_hold),
        .limit (timer_lim),
        .tc    (tc)
    );

    // Next-state decode; a limit-switch conflict overrides everything but FAULT.
    always_comb begin
        state_nxt = state;
        if ((state != ST_FAULT) && UP_Max && DN_Max) begin
            state_nxt = ST_FAULT;
        end else begin
            case (state)
                ST_STOPPED: begin
                    if (DN_Max)         state_nxt = ST_CLOSED;
                    else if (UP_Max)    state_nxt = ST_OPEN;
                    else if (act_pulse) state_nxt = (last_dir == DIR_DOWN) ? ST_OPENING : ST_CLOSING;
                end
                ST_CLOSED: begin
                    if (act_pulse) state_nxt = ST_OPENING;
                end
                ST_OPENING: begin
                    if (UP_Max)         state_nxt = ST_OPEN;
                    else if (tc)        state_nxt = ST_FAULT;
                    else if (act_pulse) state_nxt = PAUSE ? ST_STOPPED : ST_CLOSING;
                end
                ST_OPEN: begin
                    if (act_pulse)                        state_nxt = ST_CLOSING;
                    else if (AUTO_EN && tc && !Obstruct)  state_nxt = ST_CLOSING;
                end
                ST_CLOSING: begin
                    if (Obstruct)       state_nxt = ST_OPENING;
                    else if (DN_Max)    state_nxt = ST_CLOSED;
                    else if (tc)        state_nxt = ST_FAULT;
                    else if (act_pulse) state_nxt = PAUSE ? ST_STOPPED : ST_OPENING;
                end
                ST_FAULT: begin
                    if (Fault_Clr) state_nxt = ST_STOPPED;
                end
                default: state_nxt = ST_FAULT;
            endcase
        end
    end

    // State, direction memory and motor/fault outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_STOPPED;
            last_dir <= DIR_DOWN;
            act_d    <= 1'b1;
            UP_M     <= 1'b0;
            DN_M     <= 1'b0;
            Fault    <= 1'b0;
        end else begin
            state <= state_nxt;
            act_d <= Activate;
            UP_M  <= (state_nxt == ST_OPENING);
            DN_M  <= (state_nxt == ST_CLOSING);
            Fault <= (state_nxt == ST_FAULT);
            if (state_nxt == ST_OPENING) begin
                last_dir <= DIR_UP;
            end else if (state_nxt == ST_CLOSING) begin
                last_dir <= DIR_DOWN;
            end
        end
    end

    assign State = state;

endmodule

// File: tb/tb_garage_door_ctrl_p.sv
// Directed plus randomized bench for garage_door_ctrl_p against a behavioural model.
module tb_garage_door_ctrl_p;

    localparam int S_CLOSED  = 0;
    localparam int S_OPENING = 1;
    localparam int S_OPEN    = 2;
    localparam int S_CLOSING = 3;
    localparam int S_STOPPED = 4;
    localparam int S_FAULT   = 5;
    localparam int D_DOWN    = 0;
    localparam int D_UP      = 1;
    localparam int N_DUT     = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic Activate = 1'b0;
    logic UP_Max = 1'b0;
    logic DN_Max = 1'b0;
    logic Obstruct = 1'b0;
    logic Fault_Clr = 1'b0;

    logic [2:0] st_o [N_DUT];
    logic       up_o [N_DUT];
    logic       dn_o [N_DUT];
    logic       flt_o[N_DUT];

    int n_assert = 0;
    int n_fail   = 0;

    // Instance 0: pause mode; 1: reverse mode; 2: pause mode with auto-close
    int p_to[N_DUT] = '{16, 16, 16};
    int p_ac[N_DUT] = '{0, 0, 8};
    int p_pm[N_DUT] = '{1, 0, 1};

    int m_st [N_DUT];
    int m_dir[N_DUT];
    int m_cnt[N_DUT];
    bit m_actd[N_DUT];

    garage_door_ctrl_p #(.TIMEOUT_CYC(16), .AUTO_CLOSE_CYC(0), .PAUSE_MODE(1)) u_pause (
        .clk(clk), .rst(rst), .Activate(Activate), .UP_Max(UP_Max), .DN_Max(DN_Max),
        .Obstruct(Obstruct), .Fault_Clr(Fault_Clr),
        .UP_M(up_o[0]), .DN_M(dn_o[0]), .Fault(flt_o[0]), .State(st_o[0]));

    garage_door_ctrl_p #(.TIMEOUT_CYC(16), .AUTO_CLOSE_CYC(0), .PAUSE_MODE(0)) u_rev (
        .clk(clk), .rst(rst), .Activate(Activate), .UP_Max(UP_Max), .DN_Max(DN_Max),
        .Obstruct(Obstruct), .Fault_Clr(Fault_Clr),
        .UP_M(up_o[1]), .DN_M(dn_o[1]), .Fault(flt_o[1]), .State(st_o[1]));

    garage_door_ctrl_p #(.TIMEOUT_CYC(16), .AUTO_CLOSE_CYC(8), .PAUSE_MODE(1)) u_auto (
        .clk(clk), .rst(rst), .Activate(Activate), .UP_Max(UP_Max), .DN_Max(DN_Max),
        .Obstruct(Obstruct), .Fault_Clr(Fault_Clr),
        .UP_M(up_o[2]), .DN_M(dn_o[2]), .Fault(flt_o[2]), .State(st_o[2]));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural model: door position state plus cycles spent in the current state.
    task automatic model_step(input int i);
        bit ap;
        bit to_hit;
        bit ac_hit;
        int ns;
        ap     = Activate && !m_actd[i];
        to_hit = (m_cnt[i] == p_to[i] - 1);
        ac_hit = (p_ac[i] != 0) && (m_cnt[i] == p_ac[i] - 1) && !Obstruct;
        if (rst) begin
            m_st[i]   = S_STOPPED;
            m_dir[i]  = D_DOWN;
            m_cnt[i]  = 0;
            m_actd[i] = 1'b1;
        end else begin
            m_actd[i] = Activate;
            ns = m_st[i];
            if (m_st[i] != S_FAULT && UP_Max && DN_Max) ns = S_FAULT;
            else if (m_st[i] == S_STOPPED) begin
                if (DN_Max) ns = S_CLOSED;
                else if (UP_Max) ns = S_OPEN;
                else if (ap) ns = (m_dir[i] == D_DOWN) ? S_OPENING : S_CLOSING;
            end else if (m_st[i] == S_CLOSED) begin
                if (ap) ns = S_OPENING;
            end else if (m_st[i] == S_OPENING) begin
                if (UP_Max) ns = S_OPEN;
                else if (to_hit) ns = S_FAULT;
                else if (ap) ns = (p_pm[i] != 0) ? S_STOPPED : S_CLOSING;
            end else if (m_st[i] == S_OPEN) begin
                if (ap || ac_hit) ns = S_CLOSING;
            end else if (m_st[i] == S_CLOSING) begin
                if (Obstruct) ns = S_OPENING;
                else if (DN_Max) ns = S_CLOSED;
                else if (to_hit) ns = S_FAULT;
                else if (ap) ns = (p_pm[i] != 0) ? S_STOPPED : S_OPENING;
            end else if (m_st[i] == S_FAULT) begin
                if (Fault_Clr) ns = S_STOPPED;
            end
            if (ns == S_OPENING) m_dir[i] = D_UP;
            if (ns == S_CLOSING) m_dir[i] = D_DOWN;
            if (ns != m_st[i]) m_cnt[i] = 0;
            else if (m_st[i] == S_OPENING || m_st[i] == S_CLOSING ||
                     (m_st[i] == S_OPEN && !Obstruct)) begin
                if (m_cnt[i] < 1000) m_cnt[i] = m_cnt[i] + 1;
            end
            m_st[i] = ns;
        end
    endtask

    // One clock: advance the model on the edge, compare every DUT just after it.
    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < N_DUT; i++) model_step(i);
        #1;
        for (int i = 0; i < N_DUT; i++) begin
            chk($sformatf("state[%0d]", i), 32'(st_o[i]), 32'(m_st[i]));
            chk($sformatf("up_m[%0d]", i), 32'(up_o[i]), (m_st[i] == S_OPENING) ? 1 : 0);
            chk($sformatf("dn_m[%0d]", i), 32'(dn_o[i]), (m_st[i] == S_CLOSING) ? 1 : 0);
            chk($sformatf("fault[%0d]", i), 32'(flt_o[i]), (m_st[i] == S_FAULT) ? 1 : 0);
            chk($sformatf("motors_exclusive[%0d]", i), 32'(up_o[i] & dn_o[i]), 0);
        end
    endtask

    initial begin
        int n_open;
        int n_up;
        logic [2:0] prev;

        // 1. normal cycle
        DN_Max = 1'b1;
        rst = 1'b1;
        tick();
        chk("t1_reset_state", 32'(st_o[0]), S_STOPPED);
        chk("t1_reset_outputs", 32'(up_o[0] | dn_o[0] | flt_o[0]), 0);
        rst = 1'b0;
        tick();
        chk("t1_closed", 32'(st_o[0]), S_CLOSED);
        Activate = 1'b1;
        DN_Max = 1'b0;
        tick();
        chk("t1_up_m_on", 32'(up_o[0]), 1);
        repeat (4) tick();
        UP_Max = 1'b1;
        tick();
        chk("t1_open", 32'(st_o[0]), S_OPEN);
        chk("t1_up_m_off", 32'(up_o[0]), 0);
        Activate = 1'b0;
        UP_Max = 1'b0;
        tick();
        Activate = 1'b1;
        tick();
        chk("t1_dn_m_on", 32'(dn_o[0]), 1);
        repeat (3) tick();
        DN_Max = 1'b1;
        tick();
        chk("t1_closed_again", 32'(st_o[0]), S_CLOSED);

        // 2. held button gives one opening
        Activate = 1'b0;
        tick();
        Activate = 1'b1;
        n_open = 0;
        prev = st_o[0];
        for (int k = 0; k < 10; k++) begin
            tick();
            DN_Max = 1'b0;
            if (st_o[0] == 3'(S_OPENING) && prev != 3'(S_OPENING)) n_open++;
            prev = st_o[0];
        end
        chk("t2_single_opening", 32'(n_open), 1);
        chk("t2_still_opening", 32'(st_o[0]), S_OPENING);

        // 3/4. pause then resume the other way; reverse mode flips directly
        Activate = 1'b0;
        tick();
        Activate = 1'b1;
        tick();
        chk("t3_paused", 32'(st_o[0]), S_STOPPED);
        chk("t3_paused_motors", 32'(up_o[0] | dn_o[0]), 0);
        chk("t4_reverse_to_closing", 32'(st_o[1]), S_CLOSING);
        Activate = 1'b0;
        tick();
        Activate = 1'b1;
        tick();
        chk("t3_resume_closing", 32'(st_o[0]), S_CLOSING);
        chk("t4_reverse_to_opening", 32'(st_o[1]), S_OPENING);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        Activate = 1'b0;
        tick();

        // 5. travel timeout
        Activate = 1'b1;
        tick();
        n_up = up_o[0] ? 1 : 0;
        Activate = 1'b0;
        for (int k = 0; k < 40 && !flt_o[0]; k++) begin
            tick();
            if (up_o[0]) n_up++;
        end
        chk("t5_up_m_cycles", 32'(n_up), 16);
        chk("t5_fault", 32'(flt_o[0]), 1);
        chk("t5_fault_state", 32'(st_o[0]), S_FAULT);
        Activate = 1'b1;
        tick();
        chk("t5_activate_ignored", 32'(st_o[0]), S_FAULT);
        Activate = 1'b0;
        Fault_Clr = 1'b1;
        tick();
        chk("t5_fault_cleared", 32'(st_o[0]), S_STOPPED);
        Fault_Clr = 1'b0;

        // 6. obstruction, auto-close, reset mid-travel
        Activate = 1'b1;
        tick();
        chk("t6_closing", 32'(st_o[0]), S_CLOSING);
        Activate = 1'b0;
        repeat (2) tick();
        Obstruct = 1'b1;
        DN_Max = 1'b1;
        tick();
        chk("t6_obstruct_beats_dn_max", 32'(st_o[0]), S_OPENING);
        Obstruct = 1'b0;
        DN_Max = 1'b0;
        UP_Max = 1'b1;
        tick();
        chk("t6_open", 32'(st_o[2]), S_OPEN);
        repeat (7) tick();
        chk("t6_auto_not_yet", 32'(st_o[2]), S_OPEN);
        tick();
        chk("t6_auto_close", 32'(st_o[2]), S_CLOSING);
        chk("t6_auto_disabled_stays_open", 32'(st_o[0]), S_OPEN);
        Obstruct = 1'b1;
        tick();
        tick();
        repeat (20) tick();
        chk("t6_obstruct_holds_open", 32'(st_o[2]), S_OPEN);
        Obstruct = 1'b0;
        UP_Max = 1'b0;
        Activate = 1'b1;
        tick();
        chk("t6_closing_before_rst", 32'(st_o[0]), S_CLOSING);
        Activate = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("t6_rst_stopped", 32'(st_o[0]), S_STOPPED);
        chk("t6_rst_dn_m", 32'(dn_o[0]), 0);
        rst = 1'b0;

        // limit-switch conflict
        UP_Max = 1'b1;
        DN_Max = 1'b1;
        tick();
        chk("conflict_fault", 32'(st_o[0]), S_FAULT);
        UP_Max = 1'b0;
        DN_Max = 1'b0;
        Fault_Clr = 1'b1;
        tick();
        Fault_Clr = 1'b0;

        // randomized soak against the model
        repeat (3000) begin
            if ($urandom_range(0, 3) == 0) Activate = ~Activate;
            if ($urandom_range(0, 9) == 0) UP_Max = ~UP_Max;
            if ($urandom_range(0, 9) == 0) DN_Max = ~DN_Max;
            if (UP_Max && DN_Max && $urandom_range(0, 7) != 0) DN_Max = 1'b0;
            if ($urandom_range(0, 7) == 0) Obstruct = ~Obstruct;
            Fault_Clr = ($urandom_range(0, 19) == 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
